// File: rtl/aud_pkg.sv
// Shared types and constants for the multi-channel I2S recorder.
// Holds the recorder state enum, channel-mode codes and default widths.
package aud_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        SHIFT,
        STORE,
        PAUSE
    } state_t;

    localparam int CH_LEFT    = 0;
    localparam int CH_RIGHT   = 1;
    localparam int CH_STEREO  = 2;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 20;

endpackage

// File: rtl/i2s_deser.sv
// I2S deserialiser: LR-clock edge detect, delay slot and DATA_W shifter.
// Ports: clk/rst_n; lrc, data from the codec; go starts a word, kill drops it;
// edge_any/edge_ch report an LRC edge and its channel (1 = right);
// sample_valid marks the LSB cycle; abort flags an edge inside a word;
// channel/sample hold the captured word's channel and bits.
module i2s_deser
    import aud_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lrc,
    input  logic              data,
    input  logic              go,
    input  logic              kill,
    output logic              edge_any,
    output logic              edge_ch,
    output logic              sample_valid,
    output logic              abort,
    output logic              channel,
    output logic [DATA_W-1:0] sample
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    logic          lrc_q;
    logic          active;
    logic [CW-1:0] cnt;

    assign edge_any     = lrc_q != lrc;
    assign edge_ch      = lrc;
    assign abort        = active & edge_any;
    assign sample_valid = active & ~edge_any & (cnt == LAST_BIT);

    // The edge cycle itself is the I2S delay bit, so the MSB is
    // taken on the first cycle after go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lrc_q   <= 1'b0;
            active  <= 1'b0;
            cnt     <= '0;
            channel <= 1'b0;
            sample  <= '0;
        end else begin
            lrc_q <= lrc;
            if (active && !edge_any) begin
                sample <= {sample[DATA_W-2:0], data};
            end
            if (go) begin
                active  <= 1'b1;
                cnt     <= '0;
                channel <= lrc;
            end else if (kill || abort || sample_valid) begin
                active <= 1'b0;
            end else if (active) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/aud_rec_i2s_mc.sv
// I2S ADC recorder: deserialises codec samples and writes them to SRAM.
// Ports: i_clk (BCLK), i_rst_n, i_adclrck, i_data; i_start/i_pause/i_stop
// control; o_we, o_address, o_data write port; o_length, o_full, o_busy
// status; o_peak (max magnitude) only when AUD_REC_PEAK_EN is defined.
module aud_rec_i2s_mc
    import aud_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = 2 ** ADDR_W,
    parameter int CH_MODE = CH_LEFT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_adclrck,
    input  logic              i_data,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W:0]   o_length,
    output logic              o_full,
`ifdef AUD_REC_PEAK_EN
    output logic [DATA_W-1:0] o_peak,
`endif
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   len;
    logic              full;
    logic              want_r;
    logic              go;
    logic              kill;
    logic              edge_any;
    logic              edge_ch;
    logic              sample_valid;
    logic              abort;
    logic              channel;
    logic [DATA_W-1:0] sample;
    logic              wanted;
    logic              at_last;

    i2s_deser #(
        .DATA_W(DATA_W)
    ) u_deser (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .lrc         (i_adclrck),
        .data        (i_data),
        .go          (go),
        .kill        (kill),
        .edge_any    (edge_any),
        .edge_ch     (edge_ch),
        .sample_valid(sample_valid),
        .abort       (abort),
        .channel     (channel),
        .sample      (sample)
    );

    // In stereo only the channel due next is accepted, so a resume
    // after a split pair always restarts on a left edge.
    assign wanted = edge_any &
        ((CH_MODE == CH_LEFT)  ? ~edge_ch :
         (CH_MODE == CH_RIGHT) ?  edge_ch :
                                 (edge_ch == want_r));
    assign at_last = addr == LAST;

    always_comb begin
        state_n = state;
        go      = 1'b0;
        kill    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!i_stop && !i_pause && i_start) state_n = ARMED;
            end
            ARMED: begin
                if (i_stop) begin
                    state_n = IDLE;
                end else if (i_pause) begin
                    state_n = PAUSE;
                end else if (wanted) begin
                    state_n = DELAY;
                    go      = 1'b1;
                end
            end
            DELAY, SHIFT: begin
                if (i_stop) begin
                    state_n = IDLE;
                    kill    = 1'b1;
                end else if (i_pause) begin
                    state_n = PAUSE;
                    kill    = 1'b1;
                end else if (abort) begin
                    if (wanted) begin
                        state_n = DELAY;
                        go      = 1'b1;
                    end else begin
                        state_n = ARMED;
                    end
                end else if (sample_valid) begin
                    state_n = STORE;
                end else begin
                    state_n = SHIFT;
                end
            end
            STORE: begin
                if (at_last || i_stop) state_n = IDLE;
                else if (i_pause)      state_n = PAUSE;
                else                   state_n = ARMED;
            end
            PAUSE: begin
                if (i_stop)                   state_n = IDLE;
                else if (!i_pause && i_start) state_n = ARMED;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            addr   <= '0;
            len    <= '0;
            full   <= 1'b0;
            want_r <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n == ARMED) begin
                addr <= '0;
                len  <= '0;
                full <= 1'b0;
            end
            if (state == STORE) begin
                len    <= len + (ADDR_W + 1)'(1);
                want_r <= (CH_MODE == CH_STEREO) && !channel;
                if (at_last) full <= 1'b1;
                else         addr <= addr + ADDR_W'(1);
            end
            if (state_n == IDLE || state_n == PAUSE) want_r <= 1'b0;
        end
    end

`ifdef AUD_REC_PEAK_EN
    localparam logic [DATA_W-1:0] MAXP = {1'b0, {(DATA_W-1){1'b1}}};

    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] peak;

    // The most negative code has no positive twin; clamp it.
    always_comb begin
        mag = sample;
        if (sample[DATA_W-1]) mag = (sample == ~MAXP) ? MAXP : -sample;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            peak <= '0;
        end else if (state == IDLE && state_n == ARMED) begin
            peak <= '0;
        end else if (state == STORE && mag > peak) begin
            peak <= mag;
        end
    end

    assign o_peak = peak;
`endif

    assign o_we      = state == STORE;
    assign o_address = addr;
    assign o_data    = sample;
    assign o_length  = len;
    assign o_full    = full;
    assign o_busy    = state inside {ARMED, DELAY, SHIFT, STORE};

endmodule

// File: tb/tb_aud_rec_i2s_mc.sv
// Directed bench for aud_rec_i2s_mc: mono-left 16b/depth 8, stereo 16b,
// and mono-right 24b instances fed from one I2S stream.
module tb_aud_rec_i2s_mc;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       lrc   = 1'b1;
    logic       sd    = 1'b0;
    logic [2:0] start = '0;
    logic [2:0] pause = '0;
    logic [2:0] stop  = '0;
    int         cyc   = 0;
    int         total = 0;
    int         bad   = 0;
    int         t_left = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_we, a_full, a_busy;
    logic [2:0]  a_addr;
    logic [15:0] a_data;
    logic [3:0]  a_len;
    logic        b_we, b_full, b_busy;
    logic [3:0]  b_addr;
    logic [15:0] b_data;
    logic [4:0]  b_len;
    logic        c_we, c_full, c_busy;
    logic [3:0]  c_addr;
    logic [23:0] c_data;
    logic [4:0]  c_len;
`ifdef AUD_REC_PEAK_EN
    logic [15:0] a_peak, b_peak;
    logic [23:0] c_peak;
`endif

    aud_rec_i2s_mc #(.DATA_W(16), .ADDR_W(3), .CH_MODE(0)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_adclrck(lrc), .i_data(sd),
        .i_start(start[0]), .i_pause(pause[0]), .i_stop(stop[0]),
        .o_we(a_we), .o_address(a_addr), .o_data(a_data),
        .o_length(a_len), .o_full(a_full),
`ifdef AUD_REC_PEAK_EN
        .o_peak(a_peak),
`endif
        .o_busy(a_busy));

    aud_rec_i2s_mc #(.DATA_W(16), .ADDR_W(4), .CH_MODE(2)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_adclrck(lrc), .i_data(sd),
        .i_start(start[1]), .i_pause(pause[1]), .i_stop(stop[1]),
        .o_we(b_we), .o_address(b_addr), .o_data(b_data),
        .o_length(b_len), .o_full(b_full),
`ifdef AUD_REC_PEAK_EN
        .o_peak(b_peak),
`endif
        .o_busy(b_busy));

    aud_rec_i2s_mc #(.DATA_W(24), .ADDR_W(4), .CH_MODE(1)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_adclrck(lrc), .i_data(sd),
        .i_start(start[2]), .i_pause(pause[2]), .i_stop(stop[2]),
        .o_we(c_we), .o_address(c_addr), .o_data(c_data),
        .o_length(c_len), .o_full(c_full),
`ifdef AUD_REC_PEAK_EN
        .o_peak(c_peak),
`endif
        .o_busy(c_busy));

    int          na = 0, nb = 0, nc = 0;
    logic [2:0]  wa_addr [32];
    logic [15:0] wa_data [32];
    int          wa_cyc  [32];
    logic [3:0]  wb_addr [32];
    logic [15:0] wb_data [32];
    int          wb_cyc  [32];
    logic [3:0]  wc_addr [32];
    logic [23:0] wc_data [32];

    always @(negedge clk) begin
        if (a_we) begin
            if (na < 32) begin
                wa_addr[na] = a_addr;
                wa_data[na] = a_data;
                wa_cyc[na]  = cyc;
            end
            na++;
        end
        if (b_we) begin
            if (nb < 32) begin
                wb_addr[nb] = b_addr;
                wb_data[nb] = b_data;
                wb_cyc[nb]  = cyc;
            end
            nb++;
        end
        if (c_we) begin
            if (nc < 32) begin
                wc_addr[nc] = c_addr;
                wc_data[nc] = c_data;
            end
            nc++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // k=0 carries the delay bit; MSB follows on k=1.
    task automatic send_half(input logic lr, input logic [31:0] slot,
                             input int len);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k == 0 && !lr) t_left = cyc;
            lrc = lr;
            if (k == 0) sd = 1'b0;
            else        sd = slot[32-k];
        end
    endtask

    task automatic frame(input logic [31:0] l, input logic [31:0] r);
        send_half(1'b0, l, 32);
        send_half(1'b1, r, 32);
    endtask

    task automatic pulse(input int idx, input logic p, input logic s,
                         input logic g);
        @(negedge clk);
        pause[idx] = p;
        stop[idx]  = s;
        start[idx] = g;
        @(negedge clk);
        pause[idx] = 1'b0;
        stop[idx]  = 1'b0;
        start[idx] = 1'b0;
    endtask

    logic [15:0] fill [8];

    initial begin
        fill = '{16'h0100, 16'hFF00, 16'h8000, 16'h0010,
                 16'h0020, 16'h0030, 16'h0040, 16'h0050};
        repeat (3) @(negedge clk);
        check("rst_we",   a_we,   0);
        check("rst_addr", a_addr, 0);
        check("rst_len",  a_len,  0);
        check("rst_full", a_full, 0);
        check("rst_busy", a_busy, 0);
        check("rst_data", a_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        start = 3'b111;
        @(negedge clk);
        start = 3'b000;
        check("armed_busy", a_busy, 1);

        frame(32'hF0E1_0000, 32'hABCD_EF00);
        check("a_n1",     na, 1);
        check("a_addr0",  wa_addr[0], 0);
        check("a_data0",  wa_data[0], 16'hF0E1);
        check("a_lat",    wa_cyc[0], t_left + 17);
        check("c_n1",     nc, 1);
        check("c_addr0",  wc_addr[0], 0);
        check("c_data0",  wc_data[0], 24'hABCDEF);
        check("b_n1",     nb, 2);
        check("b_data0",  wb_data[0], 16'hF0E1);
        check("b_data1",  wb_data[1], 16'hABCD);
        check("b_gap",    wb_cyc[1] - wb_cyc[0], 32);

        frame(32'hD2C3_0000, 32'h9687_0000);
        check("a_n2",     na, 2);
        check("a_addr1",  wa_addr[1], 1);
        check("a_data1",  wa_data[1], 16'hD2C3);
        check("a_len2",   a_len, 2);
        check("b_len4",   b_len, 4);
        check("b_addr3",  wb_addr[3], 3);
        check("b_data3",  wb_data[3], 16'h9687);
        check("c_data1",  wc_data[1], 24'h968700);

        send_half(1'b0, 32'h1234_0000, 10);
        send_half(1'b1, 32'h0, 32);
        check("abort_n",   na, 2);
        check("abort_len", a_len, 2);

        frame(32'h5A5A_0000, 32'h0);
        check("a_addr2", wa_addr[2], 2);
        check("a_data2", wa_data[2], 16'h5A5A);

        fork
            send_half(1'b0, 32'h7777_0000, 32);
            begin
                repeat (7) @(negedge clk);
                pulse(0, 1'b1, 1'b0, 1'b0);
            end
        join
        send_half(1'b1, 32'h0, 32);
        check("pause_n",    na, 3);
        check("pause_busy", a_busy, 0);
        check("pause_addr", a_addr, 3);
        check("pause_len",  a_len, 3);

        pulse(0, 1'b0, 1'b0, 1'b1);
        frame(32'h3C3C_0000, 32'h0);
        check("resume_n",    na, 4);
        check("resume_addr", wa_addr[3], 3);
        check("resume_data", wa_data[3], 16'h3C3C);
        check("resume_len",  a_len, 4);

        fork
            send_half(1'b0, 32'h1111_0000, 32);
            begin
                repeat (7) @(negedge clk);
                pulse(0, 1'b0, 1'b1, 1'b1);
            end
        join
        send_half(1'b1, 32'h0, 32);
        check("stop_n",    na, 4);
        check("stop_busy", a_busy, 0);
        check("stop_len",  a_len, 4);
        check("stop_addr", a_addr, 4);

        pulse(0, 1'b0, 1'b0, 1'b1);
        check("restart_addr", a_addr, 0);
        check("restart_len",  a_len, 0);
        check("restart_busy", a_busy, 1);

        for (int i = 0; i < 8; i++) frame({fill[i], 16'h0000}, 32'h0);
        frame(32'h2222_0000, 32'h0);
        check("full_n",    na, 12);
        check("full_flag", a_full, 1);
        check("full_busy", a_busy, 0);
        check("full_len",  a_len, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("fill_addr%0d", i), wa_addr[4+i], i);
            check($sformatf("fill_data%0d", i), wa_data[4+i], fill[i]);
        end
`ifdef AUD_REC_PEAK_EN
        check("peak", a_peak, 16'h7FFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
